// File: rtl/cpu_pkg.sv
// cpu_pkg: shared CPU definitions.
//   XLEN             - datapath width
//   RESET_PC_DEFAULT - default PC loaded on reset
//   NOP_INSTR        - addi x0,x0,0, held in IF/ID while it is empty after reset
//   if_id_t          - IF/ID pipeline register payload {pc, pc_plus4, instr}
//   align_word()     - clears the two byte-offset bits of an address
package cpu_pkg;

  localparam int          XLEN             = 32;
  localparam logic [31:0] RESET_PC_DEFAULT = 32'h0000_0000;
  localparam logic [31:0] NOP_INSTR        = 32'h0000_0013;

  typedef struct packed {
    logic [XLEN-1:0] pc;
    logic [XLEN-1:0] pc_plus4;
    logic [XLEN-1:0] instr;
  } if_id_t;

  function automatic logic [XLEN-1:0] align_word(input logic [XLEN-1:0] a);
    return {a[XLEN-1:2], 2'b00};
  endfunction

endpackage

// File: rtl/pc_reg.sv
// pc_reg: program counter register with next-PC selection.
//   clk, rst           - clock, synchronous active-high reset
//   i_redirect_valid   - load i_redirect_pc (word aligned) this edge
//   i_redirect_pc      - redirect target
//   i_advance          - step to PC+4 this edge (IF/ID slot accepted a fetch)
//   o_pc               - current PC (always word aligned)
//   o_pc_plus4         - o_pc + 4, modulo 2^XLEN
module pc_reg
  import cpu_pkg::*;
#(
  parameter logic [XLEN-1:0] RESET_PC = RESET_PC_DEFAULT
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            i_redirect_valid,
  input  logic [XLEN-1:0] i_redirect_pc,
  input  logic            i_advance,
  output logic [XLEN-1:0] o_pc,
  output logic [XLEN-1:0] o_pc_plus4
);

  logic [XLEN-1:0] r_pc;
  logic [XLEN-1:0] w_pc_plus4;
  logic [XLEN-1:0] w_pc_next;

  // Wraps naturally: 0xFFFF_FFFC + 4 = 0.
  assign w_pc_plus4 = r_pc + XLEN'(4);

  // Redirect outranks sequential advance; otherwise hold (stall).
  always_comb begin
    w_pc_next = r_pc;
    if (i_redirect_valid)
      w_pc_next = align_word(i_redirect_pc);
    else if (i_advance)
      w_pc_next = w_pc_plus4;
  end

  // Every value loaded is aligned, so r_pc[1:0] stays 2'b00.
  always_ff @(posedge clk) begin
    if (rst)
      r_pc <= align_word(RESET_PC);
    else
      r_pc <= w_pc_next;
  end

  assign o_pc       = r_pc;
  assign o_pc_plus4 = w_pc_plus4;

endmodule

// File: rtl/fetch_stage.sv
// fetch_stage: instruction fetch with a single IF/ID register and
// valid/ready handshake to decode.
//   clk, rst        - clock, synchronous active-high reset
//   imem_addr       - fetch address to instruction memory (PC register)
//   imem_instr      - combinational instruction word for imem_addr
//   redirect_valid  - branch/jump/trap redirect from execute
//   redirect_pc     - redirect target (low two bits ignored)
//   out_valid       - IF/ID holds a valid instruction
//   out_ready       - decode accepts IF/ID this cycle
//   out_pc          - PC of the IF/ID instruction
//   out_instr       - IF/ID instruction word
//   out_pc_plus4    - out_pc + 4
//   fetch_count     - accepted handshakes since reset (wraps)
module fetch_stage
  import cpu_pkg::*;
#(
  parameter logic [XLEN-1:0] RESET_PC = RESET_PC_DEFAULT
) (
  input  logic            clk,
  input  logic            rst,
  output logic [XLEN-1:0] imem_addr,
  input  logic [XLEN-1:0] imem_instr,
  input  logic            redirect_valid,
  input  logic [XLEN-1:0] redirect_pc,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [XLEN-1:0] out_pc,
  output logic [XLEN-1:0] out_instr,
  output logic [XLEN-1:0] out_pc_plus4,
  output logic [XLEN-1:0] fetch_count
);

  logic [XLEN-1:0] w_pc;
  logic [XLEN-1:0] w_pc_plus4;
  logic            w_slot_free;
  logic            w_handshake;
  logic            w_fetch;

  if_id_t          r_if_id;
  logic            r_valid;
  logic [XLEN-1:0] r_fetch_count;

  assign w_slot_free = !r_valid || out_ready;
  assign w_handshake = r_valid && out_ready;
  // A redirect squashes the word fetched this cycle, so PC and IF/ID
  // only advance sequentially when no redirect is pending.
  assign w_fetch     = w_slot_free && !redirect_valid;

  pc_reg #(
    .RESET_PC(RESET_PC)
  ) u_pc_reg (
    .clk             (clk),
    .rst             (rst),
    .i_redirect_valid(redirect_valid),
    .i_redirect_pc   (redirect_pc),
    .i_advance       (w_fetch),
    .o_pc            (w_pc),
    .o_pc_plus4      (w_pc_plus4)
  );

  // IF/ID register. A redirect only clears valid; payload is left as is.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_valid          <= 1'b0;
      r_if_id.pc       <= '0;
      r_if_id.pc_plus4 <= '0;
      r_if_id.instr    <= NOP_INSTR;
    end else if (redirect_valid) begin
      r_valid <= 1'b0;
    end else if (w_slot_free) begin
      r_valid          <= 1'b1;
      r_if_id.pc       <= w_pc;
      r_if_id.pc_plus4 <= w_pc_plus4;
      r_if_id.instr    <= imem_instr;
    end
  end

  // Counts handshakes even on redirect edges: decode already consumed
  // the instruction, the flush only drops the next one.
  always_ff @(posedge clk) begin
    if (rst)
      r_fetch_count <= '0;
    else if (w_handshake)
      r_fetch_count <= r_fetch_count + XLEN'(1);
  end

  assign imem_addr    = w_pc;
  assign out_valid    = r_valid;
  assign out_pc       = r_if_id.pc;
  assign out_instr    = r_if_id.instr;
  assign out_pc_plus4 = r_if_id.pc_plus4;
  assign fetch_count  = r_fetch_count;

endmodule
